// File: rtl/note_beat_scheduler.sv
// note_beat_scheduler: beat-tick generator and LFSR note sequencer for the
// Drums Hero note generator. Each beat steps a 4-bit LFSR. The stepped value
// becomes a lane mask, or a rest when the top two bits are zero. Notes are
// offered to the renderer over a valid/ready handshake.
// Optional build macro: DENSITY_LIMIT_EN keeps at most the two lowest set
// lanes of every note. The LFSR sequence itself is not affected.
module note_beat_scheduler #(
  parameter int unsigned CLK_DIV    = 12500000,
  parameter int unsigned SONG_BEATS = 64,
  parameter logic [3:0]  SEED       = 4'b0001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic [1:0] tempo_sel,
  output logic       note_valid,
  input  logic       note_ready,
  output logic [3:0] note_lanes,
  output logic [7:0] beat_idx,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [3:0] SEED_EFF  = (SEED == 4'b0000) ? 4'b0001 : SEED;
  localparam logic [7:0] LAST_BEAT = 8'(SONG_BEATS);

  function automatic logic [3:0] lfsr_step(input logic [3:0] v);
    return {v[2:0], v[3] ^ v[2]};
  endfunction

  function automatic logic [3:0] shape_note(input logic [3:0] v);
`ifdef DENSITY_LIMIT_EN
    logic [3:0] r;
    logic [1:0] n;
    r = 4'b0000;
    n = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (v[i] && (n != 2'd2)) begin
        r[i] = 1'b1;
        n    = n + 2'd1;
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
`else
    return v;
`endif
  endfunction

  logic [1:0]  state_q, state_d;
  logic [3:0]  lfsr_q, lfsr_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  beat_idx_q, beat_idx_d;
  logic        note_valid_q, note_valid_d;
  logic [3:0]  note_lanes_q, note_lanes_d;
  logic        overrun_q, overrun_d;
  logic [1:0]  tempo_q, tempo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [31:0] period_s;
  logic [3:0]  stepped_s;
  logic        accept_s;
  logic        at_end_s;
  logic        last_s;

  // Beat period from the latched tempo. It is clamped to at least one cycle.
  always_comb begin
    period_s = 32'(CLK_DIV) >> tempo_q;
    if (period_s == 32'd0) begin
      period_s = 32'd1;
    end else begin
      period_s = period_s;
    end
  end

  // Next-state logic: song FSM, tick counter, LFSR and note handshake.
  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    cnt_d        = cnt_q;
    beat_idx_d   = beat_idx_q;
    note_valid_d = note_valid_q;
    note_lanes_d = note_lanes_q;
    overrun_d    = overrun_q;
    tempo_d      = tempo_q;
    stepped_s    = lfsr_step(lfsr_q);
    accept_s     = note_valid_q & note_ready;
    at_end_s     = (beat_idx_q == LAST_BEAT);
    last_s       = (cnt_q == (period_s - 32'd1));

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_RUN;
          lfsr_d       = SEED_EFF;
          cnt_d        = 32'd0;
          beat_idx_d   = 8'd0;
          overrun_d    = 1'b0;
          tempo_d      = tempo_sel;
          note_valid_d = 1'b0;
          note_lanes_d = 4'b0000;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          note_valid_d = 1'b0;
          note_lanes_d = 4'b0000;
        end else begin
          note_valid_d = note_valid_q;
        end
        // Once the last beat is processed, counting stops. A pending note still drains.
        if (!pause && !at_end_s) begin
          if (last_s) begin
            if (note_valid_q && !note_ready) begin
              // Defer the tick. The counter stays parked at P-1.
              state_d   = ST_HOLD;
              overrun_d = 1'b1;
            end else begin
              cnt_d      = 32'd0;
              lfsr_d     = stepped_s;
              beat_idx_d = beat_idx_q + 8'd1;
              if (stepped_s[3:2] != 2'b00) begin
                note_valid_d = 1'b1;
                note_lanes_d = shape_note(stepped_s);
              end else begin
                note_valid_d = note_valid_d;
              end
            end
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
        if ((beat_idx_d == LAST_BEAT) && !note_valid_d) begin
          state_d = ST_DONE;
        end else begin
          state_d = state_d;
        end
      end
      ST_HOLD: begin
        // The counter stays at P-1, so the deferred tick fires on the first cycle back in RUN.
        if (accept_s) begin
          note_valid_d = 1'b0;
          note_lanes_d = 4'b0000;
          state_d      = ST_RUN;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
    done_d = (state_d == ST_DONE);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      lfsr_q       <= SEED_EFF;
      cnt_q        <= 32'd0;
      beat_idx_q   <= 8'd0;
      note_valid_q <= 1'b0;
      note_lanes_q <= 4'b0000;
      overrun_q    <= 1'b0;
      tempo_q      <= 2'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      cnt_q        <= cnt_d;
      beat_idx_q   <= beat_idx_d;
      note_valid_q <= note_valid_d;
      note_lanes_q <= note_lanes_d;
      overrun_q    <= overrun_d;
      tempo_q      <= tempo_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign note_valid = note_valid_q;
  assign note_lanes = note_lanes_q;
  assign beat_idx   = beat_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_note_beat_scheduler.sv
// Directed bench for note_beat_scheduler (CLK_DIV=8, SONG_BEATS=15, SEED=1).
module tb_note_beat_scheduler;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pause;
  logic [1:0] tempo_sel;
  logic       note_valid;
  logic       note_ready;
  logic [3:0] note_lanes;
  logic [7:0] beat_idx;
  logic       busy;
  logic       done;
  logic       overrun;

  int n_vec;
  int n_bad;

  note_beat_scheduler #(
    .CLK_DIV(8),
    .SONG_BEATS(15),
    .SEED(4'b0001)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .pause(pause),
    .tempo_sel(tempo_sel),
    .note_valid(note_valid),
    .note_ready(note_ready),
    .note_lanes(note_lanes),
    .beat_idx(beat_idx),
    .busy(busy),
    .done(done),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ready;
    logic       exp_valid;
    logic [3:0] exp_lanes;
  } beat_vec_t;

  beat_vec_t tbl [15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"},   32'(note_valid), 32'd0);
    chk({tag, ".lanes"},   32'(note_lanes), 32'd0);
    chk({tag, ".beat"},    32'(beat_idx),   32'd0);
    chk({tag, ".busy"},    32'(busy),       32'd0);
    chk({tag, ".done"},    32'(done),       32'd0);
    chk({tag, ".overrun"}, 32'(overrun),    32'd0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Stepped LFSR values from seed 1: 2,4,9,3,6,13,10,5,11,7,15,14,12,8,1.
    tbl[0]  = '{1'b1, 1'b0, 4'b0000};
    tbl[1]  = '{1'b1, 1'b1, 4'b0100};
    tbl[2]  = '{1'b1, 1'b1, 4'b1001};
    tbl[3]  = '{1'b1, 1'b0, 4'b0000};
    tbl[4]  = '{1'b1, 1'b1, 4'b0110};
    tbl[5]  = '{1'b1, 1'b1, 4'b1101};
    tbl[6]  = '{1'b1, 1'b1, 4'b1010};
    tbl[7]  = '{1'b1, 1'b1, 4'b0101};
    tbl[8]  = '{1'b1, 1'b1, 4'b1011};
    tbl[9]  = '{1'b1, 1'b1, 4'b0111};
    tbl[10] = '{1'b1, 1'b1, 4'b1111};
    tbl[11] = '{1'b1, 1'b1, 4'b1110};
    tbl[12] = '{1'b1, 1'b1, 4'b1100};
    tbl[13] = '{1'b1, 1'b1, 4'b1000};
    tbl[14] = '{1'b1, 1'b0, 4'b0000};

    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    tempo_sel = 2'd0;
    note_ready = 1'b1;
    repeat (2) step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // Full song at P = 8>>1 = 4 with the renderer always ready.
    tempo_sel = 2'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 15; k++) begin
      note_ready = tbl[k].ready;
      repeat (4) step();
      chk("song.beat",  32'(beat_idx),   32'(k + 1));
      chk("song.valid", 32'(note_valid), 32'(tbl[k].exp_valid));
      chk("song.lanes", 32'(note_lanes), 32'(tbl[k].exp_lanes));
    end
    chk("song.done",    32'(done),    32'd1);
    chk("song.busy",    32'(busy),    32'd0);
    chk("song.overrun", 32'(overrun), 32'd0);

    // Restart from DONE, then stall the renderer after the first note.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    chk("bp.first_lanes", 32'(note_lanes), 32'h4);
    chk("bp.first_beat",  32'(beat_idx),   32'd2);
    note_ready = 1'b0;
    repeat (10) step();
    chk("bp.held_lanes", 32'(note_lanes), 32'h4);
    chk("bp.held_valid", 32'(note_valid), 32'd1);
    chk("bp.overrun",    32'(overrun),    32'd1);
    chk("bp.held_beat",  32'(beat_idx),   32'd2);
    chk("bp.busy",       32'(busy),       32'd1);
    note_ready = 1'b1;
    step();
    chk("bp.accept_valid", 32'(note_valid), 32'd0);
    chk("bp.accept_beat",  32'(beat_idx),   32'd2);
    step();
    chk("bp.deferred_lanes", 32'(note_lanes), 32'h9);
    chk("bp.deferred_beat",  32'(beat_idx),   32'd3);
    chk("bp.deferred_valid", 32'(note_valid), 32'd1);

    // Reset while a note is pending, then replay the song from SEED.
    rst = 1'b1;
    #1;
    chk("rst_async.valid", 32'(note_valid), 32'd0);
    step();
    chk_all_zero("rst_mid");
    rst = 1'b0;
    tempo_sel = 2'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("replay.beat1",  32'(beat_idx),   32'd1);
    chk("replay.valid1", 32'(note_valid), 32'd0);
    repeat (4) step();
    chk("replay.lanes2", 32'(note_lanes), 32'h4);

    // Tempo is latched at start: P = 8>>2 = 2 even after tempo_sel changes.
    reset_pulse();
    tempo_sel = 2'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    tempo_sel = 2'd0;
    repeat (2) step();
    chk("tempo.beat1",  32'(beat_idx),   32'd1);
    step();
    chk("tempo.beat1b", 32'(beat_idx),   32'd1);
    step();
    chk("tempo.beat2",  32'(beat_idx),   32'd2);
    chk("tempo.lanes2", 32'(note_lanes), 32'h4);
    repeat (2) step();
    chk("tempo.beat3",  32'(beat_idx),   32'd3);
    chk("tempo.lanes3", 32'(note_lanes), 32'h9);

    // Pause for 20 cycles freezes the counter at 1, and it resumes from there.
    reset_pulse();
    tempo_sel = 2'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    chk("pause.pre_beat", 32'(beat_idx), 32'd1);
    pause = 1'b1;
    repeat (20) step();
    chk("pause.held_beat", 32'(beat_idx),   32'd1);
    chk("pause.busy",      32'(busy),       32'd1);
    chk("pause.valid",     32'(note_valid), 32'd0);
    pause = 1'b0;
    repeat (2) step();
    chk("pause.resume_beat", 32'(beat_idx), 32'd1);
    step();
    chk("pause.tick_beat",  32'(beat_idx),   32'd2);
    chk("pause.tick_lanes", 32'(note_lanes), 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
